// File: rtl/plot_sink_fb_pkg.sv
// Shared screen geometry, colours, pixel record and sink FSM states for the plot path.
package plot_sink_fb_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  typedef enum logic {IDLE, CLEAR} state_t;

endpackage

// File: rtl/plot_sink_fb_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry while not empty.
module plot_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/plot_sink_fb.sv
// Plot sink: buffers, clips and writes pixels to the framebuffer, plus a full-screen clear.
// Optional PLOT_SINK_STATS_EN adds saturating clip_count / write_count outputs.
module plot_sink_fb
  import plot_sink_fb_pkg::*;
#(
  parameter int         WIDTH        = SCREEN_W,
  parameter int         HEIGHT       = SCREEN_H,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 plot,
  output logic                 plot_ready,
  input  logic [7:0]           x,
  input  logic [6:0]           y,
  input  logic [2:0]           colour,
  input  logic                 clear_req,
  output logic                 busy,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [2:0]           mem_data,
  output logic                 mem_wren,
  output logic                 clear_done
`ifdef PLOT_SINK_STATS_EN
  ,
  output logic [15:0]          clip_count,
  output logic [15:0]          write_count
`endif
);

  localparam logic [FB_ADDR_W-1:0] W_A    = FB_ADDR_W'(WIDTH);
  localparam logic [FB_ADDR_W-1:0] LAST_A = FB_ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [31:0]          X_LIM  = WIDTH;
  localparam logic [31:0]          Y_LIM  = HEIGHT;

  state_t               state, state_nxt;
  pixel_t               in_pix, head_pix, pix_p0;
  logic                 full, empty, accept, on_screen, pop;
  logic                 vld_p0, clr_go, clr_last;
  logic [FB_ADDR_W-1:0] clr_addr;

  assign plot_ready = !full;
  assign accept     = plot && plot_ready;
  assign on_screen  = ({24'd0, x} < X_LIM) && ({25'd0, y} < Y_LIM);
  assign in_pix     = {x, y, colour};

  // Off-screen plots are acknowledged but never enter the buffer.
  plot_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIXEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && on_screen),
    .din   (in_pix),
    .pop   (pop),
    .dout  (head_pix),
    .full  (full),
    .empty (empty)
  );

  // A pixel already in stage p0 when a clear starts is written before the first clear write.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr_go    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) state_nxt = CLEAR;
        else           pop = !empty;
      end
      CLEAR: begin
        clr_go = !vld_p0;
        if (clr_go && (clr_addr == LAST_A)) state_nxt = IDLE;
      end
    endcase
  end

  assign clr_last = clr_go && (clr_addr == LAST_A);

  // Stage p0: popped pixel
  always_ff @(posedge clk) begin
    if (pop) pix_p0 <= head_pix;
  end

  // Stage p1: registered framebuffer write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vld_p0     <= 1'b0;
      mem_wren   <= 1'b0;
      clear_done <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      clr_addr   <= '0;
    end else begin
      state      <= state_nxt;
      vld_p0     <= pop;
      mem_wren   <= vld_p0 || clr_go;
      clear_done <= clr_last;
      if (vld_p0) begin
        mem_addr <= FB_ADDR_W'(pix_p0.y) * W_A + FB_ADDR_W'(pix_p0.x);
        mem_data <= pix_p0.colour;
      end else if (clr_go) begin
        mem_addr <= clr_addr;
        mem_data <= CLEAR_COLOUR;
      end
      if (clr_go) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end
  end

  assign busy = (state == CLEAR) || !empty || vld_p0 || mem_wren;

`ifdef PLOT_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count  <= '0;
      write_count <= '0;
    end else begin
      if (accept && !on_screen && (clip_count != 16'hFFFF)) clip_count <= clip_count + 1'b1;
      if (vld_p0 && (write_count != 16'hFFFF))              write_count <= write_count + 1'b1;
    end
  end
`endif

endmodule
